ui_arrow_plotter: RTL
=====================

// Module: ui_arrow_plotter
// PURPOSE
//  Parametrised arrow-glyph plotter for the 160x120 vga_adapter UI layer. On a start pulse it
//  streams one (x,y,colour,plot) pixel per step for an arrow (shaft + two 45-degree head arms)
//  centred at a latched origin, in any of four directions, draw or erase. Replaces the
//  per-direction fixed-shape UI drawers; sits between the game FSM and the vga_adapter port.
// PARAMETERS
//  X_W        8        x coordinate width (matches adapter 160x120 mode)
//  Y_W        7        y coordinate width
//  SHAFT_LEN  8        shaft pixels incl. origin and tip; legal 1..63
//  HEAD_LEN   3        pixels per head arm (excl. tip); legal 1..31
//  X_MAX      160      x >= X_MAX is off-screen (clipped)
//  Y_MAX      120      y >= Y_MAX is off-screen (clipped)
//  PACE_DIV   1666666  clk cycles per pixel when UI_ARROW_PACE_EN defined (~30 px/s @ 50 MHz)
// PORTS
//  clk        in   1    system clock (CLOCK_50)
//  reset_n    in   1    asynchronous, active-low reset
//  start      in   1    request draw; sampled only in IDLE
//  abort      in   1    synchronous cancel; wins over every other input except reset_n
//  dir        in   2    00 UP, 01 DOWN, 10 LEFT, 11 RIGHT; latched on start
//  erase      in   1    1 = draw in colour 3'b000; latched on start
//  colour_in  in   3    RGB colour; latched on start
//  cx         in   X_W  origin x (shaft base); latched on start
//  cy         in   Y_W  origin y; latched on start
//  x          out  X_W  pixel x to adapter
//  y          out  Y_W  pixel y to adapter
//  colour     out  3    pixel colour to adapter
//  plot       out  1    write strobe to adapter
//  busy       out  1    high while a glyph is in progress
//  done       out  1    one-cycle pulse after last pixel step
// BEHAVIOUR
//  - All outputs registered. Reset (async): state IDLE, x=0, y=0, colour=0, plot=0, busy=0, done=0.
//  - FSM: IDLE -> SHAFT -> HEAD_A -> HEAD_B -> FIN -> IDLE. start in IDLE latches dir/erase/
//    colour_in/cx/cy, goes SHAFT. SHAFT steps i=0..SHAFT_LEN-1; HEAD_A, HEAD_B step j=1..HEAD_LEN;
//    FIN asserts done for exactly one cycle, returns IDLE. Total steps N = SHAFT_LEN + 2*HEAD_LEN.
//  - Pixel geometry, tip T=(tx,ty) = last shaft pixel:
//    UP    shaft (cx, cy-i)  A (tx-j, ty+j)  B (tx+j, ty+j)
//    DOWN  shaft (cx, cy+i)  A (tx-j, ty-j)  B (tx+j, ty-j)
//    LEFT  shaft (cx-i, cy)  A (tx+j, ty-j)  B (tx+j, ty+j)
//    RIGHT shaft (cx+i, cy)  A (tx-j, ty-j)  B (tx-j, ty+j)
//  - Arithmetic modulo 2^X_W / 2^Y_W (wrap, no saturation). A step whose x>=X_MAX or y>=Y_MAX
//    still consumes its slot but drives plot=0 (x/y still driven) - step count and done timing
//    are independent of clipping.
//  - Timing (unpaced): start high at edge 0 -> busy=1 and first pixel (plot) after edge 1; pixel k
//    after edge k+1; done=1 after edge N+1, busy=0 in the same cycle; start accepted again at N+2.
//  - busy=1 from the first step cycle through the last step; 0 in IDLE and FIN.
//  - start while busy/FIN ignored (not queued). start and abort together in IDLE: abort wins.
//  - abort in any non-IDLE state: next edge -> IDLE, plot=0, busy=0, no done pulse.
//  - colour output = erase ? 3'b000 : latched colour_in for every step; plot=0 when not stepping.
//  - Inputs cx/cy/dir/colour_in changing mid-glyph have no effect (latched copies used).
// CONFIGURATION
//  UI_ARROW_PACE_EN defined: an internal down-counter (width clog2(PACE_DIV)) reloads PACE_DIV-1
//    on start; a step (and its plot pulse, 1 cycle wide) occurs only on counter==0, so pixel k
//    appears PACE_DIV*(k+1) cycles after start; busy stays high between steps; done follows the
//    last step by PACE_DIV cycles; abort also clears the counter. Animated "growing arrow".
//  Undefined: no pace counter synthesised; one step per clk as in Timing above.
// TESTING
//  1. Reset mid-glyph (reset_n low at step 5) -> all outputs 0 immediately, IDLE; next start redraws from step 0.
//  2. UP, cx=79, cy=63, colour_in=3'b100 -> 14 plot pulses: (79,63)..(79,56), A (78,57)(77,58)(76,59),
//     B (80,57)(81,58)(82,59); colour=100 each; done at cycle 15; busy high cycles 1..14.
//  3. RIGHT, cx=155, cy=10, erase=1 -> shaft x 155..159 plotted, x=160..162 steps plot=0; colour=000;
//     done still at cycle 15.
//  4. LEFT, cx=2, cy=60 -> shaft x wraps 2,1,0,255..251 (plot=0 for 251..255); head x from tip 251 wraps.
//  5. start pulsed again at cycle 6 of a DOWN glyph -> ignored, single done pulse; abort at cycle 9
//     of next glyph -> IDLE at cycle 10, no done.
//  6. UI_ARROW_PACE_EN, PACE_DIV=4, UP default -> plot pulses at cycles 4,8,..,56; done at cycle 60.

Source files
------------

// File: rtl/ui_arrow_plotter.sv
// Arrow-glyph pixel streamer for the 160x120 vga_adapter UI layer: shaft plus two 45-degree head arms.
// Define UI_ARROW_PACE_EN to pace one pixel every PACE_DIV clocks (animated growing arrow).
module ui_arrow_plotter #(
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int SHAFT_LEN = 8,
   parameter int HEAD_LEN  = 3,
   parameter int X_MAX     = 160,
   parameter int Y_MAX     = 120,
   parameter int PACE_DIV  = 1666666
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic           abort,
   input  logic [1:0]     dir,
   input  logic           erase,
   input  logic [2:0]     colour_in,
   input  logic [X_W-1:0] cx,
   input  logic [Y_W-1:0] cy,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic [2:0]     colour,
   output logic           plot,
   output logic           busy,
   output logic           done
);

   localparam int IDX_W = 6;
   localparam logic [1:0] D_UP = 2'b00, D_DOWN = 2'b01, D_LEFT = 2'b10, D_RIGHT = 2'b11;

   typedef enum logic [2:0] {IDLE, SHAFT, HEAD_A, HEAD_B, FIN} state_t;
   state_t state, state_next;

   logic [IDX_W-1:0] idx;
   logic [1:0]       dir_q;
   logic             erase_q;
   logic [2:0]       colour_q;
   logic [X_W-1:0]   cx_q, tx, ix, px;
   logic [Y_W-1:0]   cy_q, ty, iy, py;
   logic             step_en, stepping, on_screen, last_shaft, last_head;

`ifdef UI_ARROW_PACE_EN
   localparam int PACE_W = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;
   logic [PACE_W-1:0] pace_cnt;

   assign step_en = (pace_cnt == '0);

   // Reloads on start and after every step slot so each slot lasts exactly PACE_DIV clocks.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         pace_cnt <= '0;
      else if (abort)
         pace_cnt <= '0;
      else if (state == IDLE)
         pace_cnt <= start ? PACE_W'(PACE_DIV - 1) : '0;
      else if (pace_cnt == '0)
         pace_cnt <= (state == FIN) ? '0 : PACE_W'(PACE_DIV - 1);
      else
         pace_cnt <= pace_cnt - 1'b1;
   end
`else
   assign step_en = 1'b1;
`endif

   assign last_shaft = (idx == IDX_W'(SHAFT_LEN - 1));
   assign last_head  = (idx == IDX_W'(HEAD_LEN));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (abort)
         state_next = IDLE;
      else begin
         unique case (state)
            IDLE:    if (start) state_next = SHAFT;
            SHAFT:   if (step_en && last_shaft) state_next = HEAD_A;
            HEAD_A:  if (step_en && last_head) state_next = HEAD_B;
            HEAD_B:  if (step_en && last_head) state_next = FIN;
            FIN:     if (step_en) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Pixel for the current step; all coordinate arithmetic wraps at the port widths.
   always_comb begin
      ix = X_W'(idx);
      iy = Y_W'(idx);
      tx = cx_q;
      ty = cy_q;
      unique case (dir_q)
         D_UP:    ty = cy_q - Y_W'(SHAFT_LEN - 1);
         D_DOWN:  ty = cy_q + Y_W'(SHAFT_LEN - 1);
         D_LEFT:  tx = cx_q - X_W'(SHAFT_LEN - 1);
         default: tx = cx_q + X_W'(SHAFT_LEN - 1);
      endcase
      px = cx_q;
      py = cy_q;
      if (state == SHAFT) begin
         px = tx;
         py = ty;
         unique case (dir_q)
            D_UP:    py = cy_q - iy;
            D_DOWN:  py = cy_q + iy;
            D_LEFT:  px = cx_q - ix;
            default: px = cx_q + ix;
         endcase
      end else if (state == HEAD_A || state == HEAD_B) begin
         px = (dir_q == D_LEFT || (dir_q != D_RIGHT && state == HEAD_B)) ? tx + ix : tx - ix;
         py = (dir_q == D_UP   || (dir_q != D_DOWN  && state == HEAD_B)) ? ty + iy : ty - iy;
      end
      stepping  = step_en && (state == SHAFT || state == HEAD_A || state == HEAD_B);
      on_screen = (32'(px) < X_MAX) && (32'(py) < Y_MAX);
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && start && !abort) begin
         dir_q    <= dir;
         erase_q  <= erase;
         colour_q <= colour_in;
         cx_q     <= cx;
         cy_q     <= cy;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx    <= '0;
         x      <= '0;
         y      <= '0;
         colour <= '0;
         plot   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else if (abort) begin
         idx  <= '0;
         plot <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         plot <= 1'b0;
         done <= 1'b0;
         if (stepping) begin
            x      <= px;
            y      <= py;
            colour <= erase_q ? 3'b000 : colour_q;
            plot   <= on_screen;
            busy   <= 1'b1;
            if ((state == SHAFT && last_shaft) || (state != SHAFT && last_head))
               idx <= IDX_W'(1);
            else
               idx <= idx + 1'b1;
         end else if (state == FIN && step_en) begin
            busy <= 1'b0;
            done <= 1'b1;
         end else if (state == IDLE) begin
            idx  <= '0;
            busy <= 1'b0;
         end
      end
   end

endmodule
